// File: rtl/hpi_pkg.sv
// Shared HPI register codes, status bit layout and a status-word packer
// for the CY7C67200 HPI stand-in.
package hpi_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    HPI_DATA    = 2'b00,
    HPI_MAILBOX = 2'b01,
    HPI_ADDRESS = 2'b10,
    HPI_STATUS  = 2'b11
  } hpi_reg_e;

  localparam int unsigned STAT_MBX_OUT_FULL = 0;
  localparam int unsigned STAT_MBX_IN_VALID = 1;
  localparam int unsigned STAT_OVERRUN      = 2;

  // STATUS register image as returned to the host
  function automatic logic [DATA_W-1:0] status_word(input logic overrun,
                                                     input logic in_valid,
                                                     input logic out_full);
    logic [DATA_W-1:0] w;
    w = '0;
    w[STAT_OVERRUN]      = overrun;
    w[STAT_MBX_IN_VALID] = in_valid;
    w[STAT_MBX_OUT_FULL] = out_full;
    return w;
  endfunction

endpackage

// File: rtl/hpi_responder_if.sv
// otg_hpi_* PIO bus between the SoC (master) and the HPI responder (slave).
interface hpi_responder_if;
  import hpi_pkg::*;

  logic [1:0]        hpi_address;
  logic              hpi_cs_n;
  logic              hpi_r_n;
  logic              hpi_w_n;
  logic              hpi_reset_n;
  logic [DATA_W-1:0] hpi_data_in;
  logic [DATA_W-1:0] hpi_data_out;
  logic              hpi_data_oe;

  modport master (
    output hpi_address, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n, hpi_data_in,
    input  hpi_data_out, hpi_data_oe
  );

  modport slave (
    input  hpi_address, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n, hpi_data_in,
    output hpi_data_out, hpi_data_oe
  );
endinterface

// File: rtl/hpi_word_ram.sv
// Word RAM: one host write port, async host read port, registered local read port.
// The local port reads old data when the host writes the same word that cycle.
module hpi_word_ram
  import hpi_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned MEM_AW = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [MEM_AW-1:0] host_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] host_rdata_c,
  input  logic [MEM_AW-1:0] lrd_addr,
  output logic [DATA_W-1:0] lrd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents survive reset; only the local read register is cleared
  always_ff @(posedge clk) begin
    if (we) mem[host_addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (clr) lrd_data <= '0;
    else     lrd_data <= mem[lrd_addr];
  end

  assign host_rdata_c = mem[host_addr];

endmodule

// File: rtl/hpi_responder.sv
// CY7C67200 HPI port emulation: strobe edge detect, auto-increment pointer,
// bidirectional mailboxes and status, backed by hpi_word_ram.
module hpi_responder
  import hpi_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned MEM_AW = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  hpi_responder_if.slave      hpi,
  output logic                mbx_in_valid,
  output logic [DATA_W-1:0]   mbx_in_data,
  input  logic                mbx_in_ack,
  input  logic                mbx_out_wr,
  input  logic [DATA_W-1:0]   mbx_out_data,
  input  logic [MEM_AW-1:0]   mem_rd_addr,
  output logic [DATA_W-1:0]   mem_rd_data
);

  logic              soft_rst_c;
  logic              r_q, w_q;
  logic              wr_fire_c, rd_fire_c;
  logic [15:0]       ptr, ptr_d, ptr_inc_c;
  logic              overrun, overrun_d;
  logic              mbx_out_full, out_full_d;
  logic [DATA_W-1:0] mbx_out_word, out_word_d;
  logic              in_valid_d;
  logic [DATA_W-1:0] in_data_d, data_out_d, ram_rdata_c;
  logic              ram_we_c;

  assign soft_rst_c = Reset | ~hpi.hpi_reset_n;

  // Strobe history is forced low in reset so a strobe held across reset never fires
  always_ff @(posedge Clk) begin
    if (soft_rst_c) begin
      r_q <= 1'b0;
      w_q <= 1'b0;
    end else begin
      r_q <= hpi.hpi_r_n;
      w_q <= hpi.hpi_w_n;
    end
  end

  assign wr_fire_c = ~soft_rst_c & ~hpi.hpi_cs_n & ~hpi.hpi_w_n & w_q;
  assign rd_fire_c = ~soft_rst_c & ~hpi.hpi_cs_n & ~hpi.hpi_r_n & r_q & ~wr_fire_c;
  assign ptr_inc_c = ptr + 16'd2;

  always_comb begin
    ptr_d      = ptr;
    overrun_d  = overrun;
    out_full_d = mbx_out_full;
    out_word_d = mbx_out_word;
    in_valid_d = mbx_in_valid;
    in_data_d  = mbx_in_data;
    data_out_d = hpi.hpi_data_out;
    ram_we_c   = 1'b0;

    if (mbx_in_ack) in_valid_d = 1'b0;
    if (mbx_out_wr) begin
      out_word_d = mbx_out_data;
      out_full_d = 1'b1;
    end

    if (wr_fire_c) begin
      case (hpi_reg_e'(hpi.hpi_address))
        HPI_ADDRESS: ptr_d = hpi.hpi_data_in;
        HPI_DATA: begin
          ram_we_c = 1'b1;
          ptr_d    = ptr_inc_c;
        end
        HPI_MAILBOX: begin
          in_data_d  = hpi.hpi_data_in;
          in_valid_d = 1'b1;
          if (mbx_in_valid && !mbx_in_ack) overrun_d = 1'b1;
        end
        default: ;
      endcase
    end

    // A local post racing a host mailbox read keeps the new word pending
    if (rd_fire_c) begin
      case (hpi_reg_e'(hpi.hpi_address))
        HPI_DATA: begin
          data_out_d = ram_rdata_c;
          ptr_d      = ptr_inc_c;
        end
        HPI_MAILBOX: begin
          data_out_d = mbx_out_word;
          if (!mbx_out_wr) out_full_d = 1'b0;
        end
        HPI_ADDRESS: data_out_d = ptr;
        HPI_STATUS: begin
          data_out_d = status_word(overrun, mbx_in_valid, mbx_out_full);
          overrun_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (soft_rst_c) begin
      ptr              <= '0;
      overrun          <= 1'b0;
      mbx_out_full     <= 1'b0;
      mbx_out_word     <= '0;
      mbx_in_valid     <= 1'b0;
      mbx_in_data      <= '0;
      hpi.hpi_data_out <= '0;
      hpi.hpi_data_oe  <= 1'b0;
    end else begin
      ptr              <= ptr_d;
      overrun          <= overrun_d;
      mbx_out_full     <= out_full_d;
      mbx_out_word     <= out_word_d;
      mbx_in_valid     <= in_valid_d;
      mbx_in_data      <= in_data_d;
      hpi.hpi_data_out <= data_out_d;
      hpi.hpi_data_oe  <= ~hpi.hpi_cs_n & ~hpi.hpi_r_n;
    end
  end

  hpi_word_ram #(.DEPTH(DEPTH), .MEM_AW(MEM_AW)) u_ram (
    .clk          (Clk),
    .clr          (soft_rst_c),
    .we           (ram_we_c),
    .host_addr    (ptr[MEM_AW:1]),
    .wdata        (hpi.hpi_data_in),
    .host_rdata_c (ram_rdata_c),
    .lrd_addr     (mem_rd_addr),
    .lrd_data     (mem_rd_data)
  );

endmodule
